mem_port_arbiter: RTL and testbench

Shares one single-ported, fixed-latency memory between the processor's instruction-fetch port and its data port, replacing the dual-port RAM hookup in the system wrapper. Each cycle it grants at most one requester using valid/ready handshakes and drives the memory. It tags every issued access in a latency-matched pipeline so each response is routed back to its owner. Data accesses win by default. An optional starvation guard bounds how long fetch can wait.

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between fetch and data ports.
// Define ARB_STARVE_GUARD_EN to bound how many consecutive data wins can starve fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic                d_wren,
  input  logic [DATA_W/8-1:0] d_mask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                mem_en,
  output logic                mem_wren,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("MEM_LAT out of range");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("STARVE_MAX out of range");
  end

  logic starve_force;
  logic grant_d, grant_if;

  // Readies are gated by RESET so nothing is accepted while reset is held.
  assign d_req_ready  = RESET & ~starve_force;
  assign if_req_ready = RESET & (~d_req_valid | starve_force);
  assign grant_d      = d_req_valid & d_req_ready;
  assign grant_if     = if_req_valid & if_req_ready & ~grant_d;

  assign mem_en    = grant_d | grant_if;
  assign mem_wren  = grant_d & d_wren;
  assign mem_mask  = grant_if ? '0 : d_mask;
  assign mem_addr  = grant_if ? if_addr : d_addr;
  assign mem_wdata = d_wdata;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_if || !if_req_valid) begin
      starve_cnt_d = '0;
    end else if (grant_d) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_force = (starve_cnt_q == 4'(STARVE_MAX)) & if_req_valid;
`else
  assign starve_force = 1'b0;
`endif

  // Owner bit: 1 = data port, 0 = fetch port.
  logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0] tag_own_q, tag_own_d;

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_own_d    = tag_own_q;
    tag_vld_d[0] = mem_en;
    tag_own_d[0] = grant_d;
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  assign if_resp_valid = tag_vld_q[MEM_LAT-1] & ~tag_own_q[MEM_LAT-1];
  assign d_resp_valid  = tag_vld_q[MEM_LAT-1] & tag_own_q[MEM_LAT-1];
  assign if_resp_data  = mem_rdata;
  assign d_resp_data   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: three arbiters (MEM_LAT 1..3) share stimulus; each has its own memory model.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0, dv = 1'b0, dw = 1'b0;
  logic [63:0] ia = '0, da = '0, dwd = '0;
  logic [7:0]  dm = '0;

  logic        if_rdy_w [3];
  logic        d_rdy_w  [3];
  logic        if_rv_w  [3];
  logic        d_rv_w   [3];
  logic        mem_en_w [3];
  logic        wren_w   [3];
  logic [7:0]  mask_w   [3];
  logic [63:0] addr_w   [3];
  logic [63:0] wdata_w  [3];
  logic [63:0] rdata_w  [3];
  logic [63:0] if_rd_w  [3];
  logic [63:0] d_rd_w   [3];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Expected arbitration for the cycle currently driven.
  logic exp_ir = 1'b0, exp_dr = 1'b0, exp_gi = 1'b0, exp_gd = 1'b0;
  int   cnt_m = 0;

  logic [1:0]  sb_own [3][16];
  logic [63:0] sb_dat [3][16];
  int          sb_due [3][16];
  logic [3:0]  wp [3];
  logic [3:0]  rp [3];

  always #5 CLK = ~CLK;

  function automatic logic [63:0] mem_val(input logic [63:0] a);
    return a * 64'h9E37_79B9_7F4A_7C15 + 64'h0123_4567_89AB_CDEF;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [63:0] pipe [g+1];

    mem_port_arbiter #(
      .ADDR_W(64), .DATA_W(64), .MEM_LAT(g + 1), .STARVE_MAX(4)
    ) u_dut (
      .CLK(CLK), .RESET(rst_n),
      .if_req_valid(iv), .if_req_ready(if_rdy_w[g]), .if_addr(ia),
      .if_resp_valid(if_rv_w[g]), .if_resp_data(if_rd_w[g]),
      .d_req_valid(dv), .d_req_ready(d_rdy_w[g]), .d_wren(dw), .d_mask(dm),
      .d_addr(da), .d_wdata(dwd), .d_resp_valid(d_rv_w[g]), .d_resp_data(d_rd_w[g]),
      .mem_en(mem_en_w[g]), .mem_wren(wren_w[g]), .mem_mask(mask_w[g]),
      .mem_addr(addr_w[g]), .mem_wdata(wdata_w[g]), .mem_rdata(rdata_w[g])
    );

    always_ff @(posedge CLK) begin
      pipe[0] <= mem_en_w[g] ? mem_val(addr_w[g]) : 64'hDEAD_BEEF_DEAD_BEEF;
      for (int i = 1; i < g + 1; i++) pipe[i] <= pipe[i-1];
    end
    assign rdata_w[g] = pipe[g];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic check_cycle();
    for (int n = 0; n < 3; n++) begin
      if (!rst_n) begin
        check_eq("rst_out", {59'd0, if_rdy_w[n], d_rdy_w[n], mem_en_w[n], if_rv_w[n], d_rv_w[n]},
                 64'd0);
        rp[n] = wp[n];
      end else begin
        if (rp[n] != wp[n] && sb_due[n][rp[n]] == cyc) begin
          check_eq("resp_owner", {62'd0, if_rv_w[n], d_rv_w[n]}, {62'd0, sb_own[n][rp[n]]});
          check_eq("resp_data", sb_own[n][rp[n]] == 2'b01 ? d_rd_w[n] : if_rd_w[n],
                   sb_dat[n][rp[n]]);
          rp[n] = rp[n] + 4'd1;
        end else begin
          check_eq("resp_idle", {62'd0, if_rv_w[n], d_rv_w[n]}, 64'd0);
        end
        check_eq("if_ready", {63'd0, if_rdy_w[n]}, {63'd0, exp_ir});
        check_eq("d_ready", {63'd0, d_rdy_w[n]}, {63'd0, exp_dr});
        check_eq("mem_en", {63'd0, mem_en_w[n]}, {63'd0, exp_gi | exp_gd});
        if (exp_gi) begin
          check_eq("if_wren", {63'd0, wren_w[n]}, 64'd0);
          check_eq("if_mask", {56'd0, mask_w[n]}, 64'd0);
          check_eq("if_addr", addr_w[n], ia);
          sb_own[n][wp[n]] = 2'b10;
          sb_dat[n][wp[n]] = mem_val(ia);
          sb_due[n][wp[n]] = cyc + n + 1;
          wp[n] = wp[n] + 4'd1;
        end else begin
          check_eq("d_wren", {63'd0, wren_w[n]}, {63'd0, exp_gd & dw});
          check_eq("d_mask", {56'd0, mask_w[n]}, {56'd0, dm});
          check_eq("d_addr", addr_w[n], da);
          check_eq("d_wdata", wdata_w[n], dwd);
          if (exp_gd) begin
            sb_own[n][wp[n]] = 2'b01;
            sb_dat[n][wp[n]] = mem_val(da);
            sb_due[n][wp[n]] = cyc + n + 1;
            wp[n] = wp[n] + 4'd1;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic ivv, input logic [63:0] iav,
                       input logic dvv, input logic dwv, input logic [7:0] dmv,
                       input logic [63:0] dav, input logic [63:0] dwdv);
    logic force_m;
    @(posedge CLK);
    cyc++;
    if (!rst_n || !iv || exp_gi) cnt_m = 0;
    else if (exp_gd) cnt_m++;
    #1;
    rst_n = r; iv = ivv; ia = iav; dv = dvv; dw = dwv; dm = dmv; da = dav; dwd = dwdv;
    if (!r) cnt_m = 0;
`ifdef ARB_STARVE_GUARD_EN
    force_m = (cnt_m == 4) && ivv;
`else
    force_m = 1'b0;
`endif
    exp_dr = r & ~force_m;
    exp_ir = r & (~dvv | force_m);
    exp_gd = dvv & exp_dr;
    exp_gi = ivv & exp_ir & ~exp_gd;
    #3;
    check_cycle();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 8'h00, '0, '0);
  endtask

  logic [9:0]  seq_pat;
  logic        p_iv, p_dv, p_dw;
  logic [63:0] p_ia, p_da, p_dwd;
  logic [7:0]  p_dm;

  initial begin
    for (int n = 0; n < 3; n++) begin
      wp[n] = '0;
      rp[n] = '0;
    end
    drive(1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 8'h00, 64'h100, '0);
    drive(1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 8'h00, 64'h100, '0);
    // Release with both valid: data read first, then fetch.
    drive(1'b1, 1'b1, 64'h0, 1'b1, 1'b0, 8'h00, 64'h100, '0);
    check_eq("first_grant_d", {63'd0, d_rdy_w[0] & ~if_rdy_w[0]}, 64'd1);
    drive(1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 8'h00, 64'h100, '0);
    check_eq("d_resp_lat1", {63'd0, d_rv_w[0]}, 64'd1);
    idle(4);
    // Masked write passes straight through.
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 8'h0F, 64'h40, 64'h1122_3344_5566_7788);
    check_eq("wr_mask", {56'd0, mask_w[0]}, 64'h0F);
    check_eq("wr_data", wdata_w[0], 64'h1122_3344_5566_7788);
    idle(4);
    // Alternating D, IF, D, IF.
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 8'h00, 64'h200 + 64'(k * 8), '0);
      else drive(1'b1, 1'b1, 64'h300 + 64'(k * 8), 1'b0, 1'b0, 8'h00, '0, '0);
    end
    idle(5);
    // Both valid continuously: guard interleaves fetch every fifth slot.
`ifdef ARB_STARVE_GUARD_EN
    seq_pat = 10'b10000_10000;
`else
    seq_pat = 10'b00000_00000;
`endif
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b1, 64'h500, 1'b1, 1'b0, 8'h00, 64'h600, '0);
      check_eq("grant_seq", {63'd0, if_rdy_w[0]}, {63'd0, seq_pat[k]});
    end
    idle(5);
    // Reset while reads are in flight: every pending response is dropped.
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 8'h00, 64'h700, '0);
    drive(1'b0, 1'b1, 64'h8, 1'b1, 1'b0, 8'h00, 64'h708, '0);
    drive(1'b0, 1'b1, 64'h8, 1'b1, 1'b0, 8'h00, 64'h708, '0);
    idle(6);
    // Fetch-only burst.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 64'(k * 8), 1'b0, 1'b0, 8'h00, '0, '0);
      check_eq("fetch_ready", {63'd0, if_rdy_w[2]}, 64'd1);
    end
    idle(5);
    // Random traffic; a request that lost holds its fields until granted.
    p_iv = 1'b0; p_dv = 1'b0; p_dw = 1'b0; p_ia = '0; p_da = '0; p_dwd = '0; p_dm = '0;
    for (int k = 0; k < 300; k++) begin
      if (!p_iv || exp_gi) begin
        p_iv = ($urandom_range(0, 3) != 0);
        p_ia = 64'($urandom_range(0, 255)) << 3;
      end
      if (!p_dv || exp_gd) begin
        p_dv  = ($urandom_range(0, 3) != 0);
        p_dw  = 1'($urandom_range(0, 1));
        p_dm  = 8'($urandom_range(0, 255));
        p_da  = 64'($urandom_range(0, 255)) << 3;
        p_dwd = {32'($urandom), 32'($urandom)};
      end
      drive(1'b1, p_iv, p_ia, p_dv, p_dw, p_dm, p_da, p_dwd);
    end
    idle(6);
    for (int n = 0; n < 3; n++) check_eq("drained", {60'd0, wp[n]}, {60'd0, rp[n]});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
